dreg_univ: RTL

//  Parametrised, clocked successor to the D latch: a WIDTH-bit edge-triggered

---
 rtl/dreg_univ.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dreg_univ.sv
// Parametrised edge-triggered register with hold/load/shift/rotate/clear/set modes.
// Optional parity output and load-parity check are enabled by defining DREG_UNIV_PARITY_EN.
module dreg_univ #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      STEP    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic [STEP-1:0]  sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [STEP-1:0]  sout,
    output logic             zero
`ifdef DREG_UNIV_PARITY_EN
    ,
    input  logic             par_chk_en,
    output logic             par,
    output logic             par_err
`endif
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_SET  = 3'b111
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [STEP-1:0]  sout_q, sout_d;

    assign mode_s = mode_e'(mode);

    // Next-state selection; en=0 falls through to the hold defaults.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (en) begin
            case (mode_s)
                MODE_HOLD: ;
                MODE_LOAD: q_d = D;
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-1-STEP:0], sin};
                    sout_d = q_q[WIDTH-1 -: STEP];
                end
                MODE_SHR: begin
                    q_d    = {sin, q_q[WIDTH-1:STEP]};
                    sout_d = q_q[STEP-1:0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-1-STEP:0], q_q[WIDTH-1 -: STEP]};
                    sout_d = q_q[WIDTH-1 -: STEP];
                end
                MODE_ROR: begin
                    q_d    = {q_q[STEP-1:0], q_q[WIDTH-1:STEP]};
                    sout_d = q_q[STEP-1:0];
                end
                MODE_CLR: begin
                    q_d    = '0;
                    sout_d = '0;
                end
                MODE_SET: q_d = '1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_VAL;
            sout_q <= '0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    // Complement and zero flag come only from the q register, never from inputs.
    assign q    = q_q;
    assign qbar = ~q_q;
    assign sout = sout_q;
    assign zero = (q_q == '0);

`ifdef DREG_UNIV_PARITY_EN
    logic par_q, par_d;
    logic par_err_q, par_err_d;

    always_comb begin
        par_d     = ^q_d;
        par_err_d = par_err_q;
        if (en) begin
            par_err_d = 1'b0;
            if (mode_s == MODE_LOAD && par_chk_en) begin
                par_err_d = (^D) != sin[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q     <= ^RST_VAL;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end

    assign par     = par_q;
    assign par_err = par_err_q;
`endif

endmodule
